// File: rtl/path_pkg.sv
// Shared types and helpers for the path reorder block: coordinates, move
// directions (same codes as the maze solver) and the controller states.
package path_pkg;

    localparam int CW = 4;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        UP    = 2'd1,
        RIGHT = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        NONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

    // Move taken from prev into cur; a zero-length step reports LEFT.
    function automatic dir_t step_dir(coord_t prev, coord_t cur);
        dir_t d;
        d = LEFT;
        if (cur.x < prev.x)      d = LEFT;
        else if (cur.y < prev.y) d = UP;
        else if (cur.x > prev.x) d = RIGHT;
        else if (cur.y > prev.y) d = DOWN;
        return d;
    endfunction

    function automatic logic is_adjacent(coord_t prev, coord_t cur);
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        dx = (cur.x > prev.x) ? cur.x - prev.x : prev.x - cur.x;
        dy = (cur.y > prev.y) ? cur.y - prev.y : prev.y - cur.y;
        return ({1'b0, dx} + {1'b0, dy}) == (CW+1)'(1);
    endfunction

endpackage

// File: rtl/path_lifo.sv
// Path stack: push on the write side, registered read of the entry that will
// be presented next (top, or the one below it when a pop happens this cycle).
module path_lifo
    import path_pkg::*;
#(
    parameter int DEPTH = 169,
    parameter int W     = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW-1:0] sp_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] sp_q, sp_d;
    logic [W-1:0]  rd_q;
    logic [AW-1:0] rd_addr;

    assign full_o    = (sp_q == AW'(DEPTH));
    assign empty_o   = (sp_q == '0);
    assign sp_o      = sp_q;
    assign rd_data_o = rd_q;

    // Look one entry deeper when the current top is being popped, so the
    // following beat is ready on the next cycle.
    assign rd_addr = pop_i ? sp_q - AW'(2) : sp_q - AW'(1);

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o)      sp_d = sp_q + AW'(1);
        else if (pop_i && !empty_o) sp_d = sp_q - AW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[sp_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            rd_q <= '0;
        end else begin
            sp_q <= sp_d;
            if (rd_en_i) rd_q <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/path_reorder.sv
// Buffers the solver's goal-to-start path and replays it start-to-goal over
// valid/ready, tagging each beat with its move direction and end markers.
module path_reorder
    import path_pkg::*;
#(
    parameter int DEPTH = 169,
    parameter int CW    = path_pkg::CW,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_none,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic [1:0]    out_dir,
    output logic          out_first,
    output logic          out_last,
    output logic [AW-1:0] path_len,
    output logic          out_none,
    output logic          err_overflow,
    output logic          err_step,
    output logic          err_drop
);

    state_t        state_q;
    logic          out_valid_q, out_first_q, out_none_q;
    logic [AW-1:0] path_len_q;
    logic          err_overflow_q, err_step_q, err_drop_q;
    coord_t        last_q;
    coord_t        prev_q;

    coord_t        in_c, cur_c;
    logic [2*CW-1:0] rd_data;
    logic [AW-1:0] sp;
    logic          full, empty;
    logic          push, pop, rd_en, xfer;

    assign in_c  = {in_x, in_y};
    assign cur_c = coord_t'(rd_data);
    assign xfer  = out_valid_q & out_ready;

    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        rd_en = 1'b0;
        case (state_q)
            IDLE:  push = in_valid & ~in_none;
            FILL:  push = in_valid & ~full;
            DRAIN: begin
                pop   = xfer;
                // Prime the read port on entry, then prefetch on every transfer.
                rd_en = ~out_valid_q | (xfer & (sp != AW'(1)));
            end
            default: ;
        endcase
    end

    path_lifo #(.DEPTH(DEPTH), .W(2*CW), .AW(AW)) u_lifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(in_c),
        .pop_i      (pop),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .sp_o       (sp),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            out_valid_q    <= 1'b0;
            out_first_q    <= 1'b0;
            out_none_q     <= 1'b0;
            path_len_q     <= '0;
            err_overflow_q <= 1'b0;
            err_step_q     <= 1'b0;
            err_drop_q     <= 1'b0;
            last_q         <= '0;
            prev_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_none) begin
                            out_none_q <= 1'b1;
                            state_q    <= NONE;
                        end else begin
                            last_q         <= in_c;
                            err_overflow_q <= 1'b0;
                            err_step_q     <= 1'b0;
                            err_drop_q     <= 1'b0;
                            state_q        <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (full) err_overflow_q <= 1'b1;
                        else      last_q         <= in_c;
                        if (!is_adjacent(last_q, in_c)) err_step_q <= 1'b1;
                    end else begin
                        path_len_q <= sp;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_valid) err_drop_q <= 1'b1;
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b1;
                    end else if (out_ready) begin
                        prev_q      <= cur_c;
                        out_first_q <= 1'b0;
                        if (sp == AW'(1)) begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                NONE: begin
                    if (in_valid) err_drop_q <= 1'b1;
                    out_none_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_x        = cur_c.x;
    assign out_y        = cur_c.y;
    assign out_dir      = (out_valid_q && !out_first_q) ? step_dir(prev_q, cur_c) : LEFT;
    assign out_first    = out_first_q;
    assign out_last     = out_valid_q & (sp == AW'(1));
    assign path_len     = path_len_q;
    assign out_none     = out_none_q;
    assign err_overflow = err_overflow_q;
    assign err_step     = err_step_q;
    assign err_drop     = err_drop_q;

endmodule

// File: tb/tb_path_reorder.sv
// Randomised bench for path_reorder: a queue-based model reverses each stream
// and predicts beats, directions, length and error flags.
module tb_path_reorder;

    localparam int DEPTH = 169;

    typedef struct { int x; int y; } pt_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_none, out_ready;
    logic [3:0] in_x, in_y;
    logic       out_valid, out_first, out_last, out_none;
    logic [3:0] out_x, out_y;
    logic [1:0] out_dir;
    logic [7:0] path_len;
    logic       err_overflow, err_step, err_drop;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    path_reorder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_none(in_none),
        .in_x(in_x), .in_y(in_y), .out_ready(out_ready), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_dir(out_dir), .out_first(out_first),
        .out_last(out_last), .path_len(path_len), .out_none(out_none),
        .err_overflow(err_overflow), .err_step(err_step), .err_drop(err_drop)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit adj(pt_t a, pt_t b);
        return (iabs(a.x - b.x) + iabs(a.y - b.y)) == 1;
    endfunction

    function automatic int mdir(pt_t p, pt_t c);
        if (c.x == p.x - 1) return 0;
        if (c.y == p.y - 1) return 1;
        if (c.x == p.x + 1) return 2;
        return 3;
    endfunction

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_stream(input pt_t s[$], input int rmode, input bit drop, input string nm);
        pt_t st[$];
        pt_t ex[$];
        pt_t last;
        bit  e_ovf, e_step, dropped, rdy;
        int  idx, cyc, budget;
        e_ovf = 0; e_step = 0; dropped = 0;
        foreach (s[i]) begin
            if (i > 0 && !adj(last, s[i])) e_step = 1;
            if (st.size() < DEPTH) begin st.push_back(s[i]); last = s[i]; end
            else e_ovf = 1;
        end
        for (int i = st.size() - 1; i >= 0; i--) ex.push_back(st[i]);

        foreach (s[i]) begin
            in_valid = 1'b1; in_none = 1'b0; in_x = 4'(s[i].x); in_y = 4'(s[i].y);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk({nm, "/valid_t1"}, 32'(out_valid), 0);
        tick();
        chk({nm, "/valid_t2"}, 32'(out_valid), 1);
        chk({nm, "/path_len"}, 32'(path_len), st.size());

        idx = 0; cyc = 0; budget = 4 * ex.size() + 50;
        while (idx < ex.size() && cyc < budget) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (drop && !dropped && idx == 2) begin
                in_valid = 1'b1; in_x = 4'($urandom); in_y = 4'($urandom); dropped = 1;
            end else in_valid = 1'b0;
            chk({nm, "/valid"}, 32'(out_valid), 1);
            if (out_valid) begin
                chk({nm, "/x"}, 32'(out_x), ex[idx].x);
                chk({nm, "/y"}, 32'(out_y), ex[idx].y);
                chk({nm, "/first"}, 32'(out_first), idx == 0);
                chk({nm, "/last"}, 32'(out_last), idx == ex.size() - 1);
                if (idx == 0) chk({nm, "/dir0"}, 32'(out_dir), 0);
                else if (adj(ex[idx-1], ex[idx]))
                    chk({nm, "/dir"}, 32'(out_dir), mdir(ex[idx-1], ex[idx]));
                if (rdy) idx++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk({nm, "/beats"}, idx, ex.size());
        chk({nm, "/valid_end"}, 32'(out_valid), 0);
        chk({nm, "/path_len_end"}, 32'(path_len), st.size());
        chk({nm, "/err_overflow"}, 32'(err_overflow), e_ovf);
        chk({nm, "/err_step"}, 32'(err_step), e_step);
        chk({nm, "/err_drop"}, 32'(err_drop), dropped);
        tick();
    endtask

    function automatic pt_t mk(int x, int y);
        pt_t p;
        p.x = x; p.y = y;
        return p;
    endfunction

    initial begin
        pt_t s[$];
        pt_t p;
        int  ln;
        rst_n = 1'b0; in_valid = 1'b0; in_none = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
        #12;
        chk("rst/out_valid", 32'(out_valid), 0);
        chk("rst/out_none", 32'(out_none), 0);
        chk("rst/path_len", 32'(path_len), 0);
        chk("rst/flags", {29'd0, err_overflow, err_step, err_drop}, 0);
        chk("rst/outs", {out_x, out_y, out_dir, out_first, out_last}, 0);
        rst_n = 1'b1;
        tick();

        // 25-cell monotone path from goal (13,13) down to start (1,1)
        p = mk(13, 13);
        s.push_back(p);
        while (p.x != 1 || p.y != 1) begin
            if (p.y == 1 || (p.x != 1 && $urandom_range(0, 1) == 1)) p.x--;
            else p.y--;
            s.push_back(p);
        end
        run_stream(s, 0, 0, "path25");
        run_stream(s, 1, 0, "path25_bp");

        // no-path marker
        in_valid = 1'b1; in_none = 1'b1;
        tick();
        in_valid = 1'b0; in_none = 1'b0;
        chk("none/pulse", 32'(out_none), 1);
        chk("none/valid", 32'(out_valid), 0);
        tick();
        chk("none/pulse_end", 32'(out_none), 0);
        chk("none/valid_end", 32'(out_valid), 0);
        tick();

        // 169-cell snake plus one more adjacent cell
        s.delete();
        for (int y = 1; y <= 13; y++)
            for (int k = 1; k <= 13; k++) s.push_back(mk((y % 2 == 1) ? k : 14 - k, y));
        s.push_back(mk(13, 14));
        run_stream(s, 2, 0, "overflow");

        s.delete();
        s.push_back(mk(3, 3)); s.push_back(mk(3, 5)); s.push_back(mk(3, 6));
        run_stream(s, 0, 0, "step");

        s.delete();
        s.push_back(mk(5, 7));
        run_stream(s, 2, 0, "len1");

        // random walks, occasional jumps and drops
        for (int t = 0; t < 8; t++) begin
            s.delete();
            ln = $urandom_range(1, 30);
            p = mk($urandom_range(0, 15), $urandom_range(0, 15));
            for (int i = 0; i < ln; i++) begin
                s.push_back(p);
                if ($urandom_range(0, 7) == 0) p = mk($urandom_range(0, 15), $urandom_range(0, 15));
                else begin
                    case ($urandom_range(0, 3))
                        0: p.x = (p.x == 0) ? 1 : p.x - 1;
                        1: p.y = (p.y == 0) ? 1 : p.y - 1;
                        2: p.x = (p.x == 15) ? 14 : p.x + 1;
                        default: p.y = (p.y == 15) ? 14 : p.y + 1;
                    endcase
                end
            end
            run_stream(s, 2, (ln >= 3) && (t % 2 == 0), $sformatf("rnd%0d", t));
        end

        // reset in the middle of a replay
        s.delete();
        for (int i = 0; i < 6; i++) s.push_back(mk(2 + i, 4));
        foreach (s[i]) begin
            in_valid = 1'b1; in_x = 4'(s[i].x); in_y = 4'(s[i].y);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid/valid_before", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid/valid", 32'(out_valid), 0);
        chk("mid/path_len", 32'(path_len), 0);
        chk("mid/outs", {out_x, out_y, out_dir, out_first, out_last, out_none}, 0);
        chk("mid/flags", {29'd0, err_overflow, err_step, err_drop}, 0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b0;
        tick();
        s.delete();
        s.push_back(mk(9, 9)); s.push_back(mk(9, 10));
        run_stream(s, 0, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/path_reorder.md
Name: path_reorder

Overview:
- Sits directly downstream of the maze solver.
- The solver emits the solved path one coordinate per cycle, goal cell first and start cell last, with no backpressure. It may instead emit a single maze-not-valid pulse.
- This block buffers the stream in a LIFO and replays it in start-to-goal order over a valid/ready handshake. Each replayed beat carries a move-direction code, first/last markers and the path length.
- It also flags overflow, non-adjacent steps and dropped input.

Parameters:
- DEPTH, 169, maximum path entries stored (13x13 interior cells).
- CW, 4, coordinate width in bits.
- AW, 8, stack pointer width; must satisfy 2^AW > DEPTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  path coordinate present (solver out_valid).
- in_none  in  1  maze-not-valid marker, qualified by in_valid.
- in_x  in  CW  column of path cell.
- in_y  in  CW  row of path cell.
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  replay beat present.
- out_x  out  CW  replayed column.
- out_y  out  CW  replayed row.
- out_dir  out  2  move from previous beat into this cell.
- out_first  out  1  first beat (start cell).
- out_last  out  1  final beat (goal cell).
- path_len  out  AW  entries stored; held stable through DRAIN.
- out_none  out  1  one-cycle pulse: upstream reported no path.
- err_overflow  out  1  sticky: more than DEPTH entries received.
- err_step  out  1  sticky: consecutive inputs not 4-adjacent.
- err_drop  out  1  sticky: in_valid arrived while not accepting.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all outputs 0; state IDLE; stack pointer 0.
- Reset mid-operation aborts immediately; stored stack contents are don't-care.
- Direction codes: LEFT=0 (x-1), UP=1 (y-1), RIGHT=2 (x+1), DOWN=3 (y+1).
- States: IDLE, FILL, DRAIN, NONE.
- IDLE, in_valid & in_none: go to NONE.
- IDLE, in_valid & !in_none:
  - push (in_x, in_y); sp=1;
  - clear all three error flags;
  - go to FILL.
- NONE: out_none=1 for exactly one cycle; out_valid stays 0; return to IDLE.
- FILL, in_valid:
  - if sp<DEPTH, push and sp++; otherwise discard the entry and set err_overflow.
  - If |dx|+|dy| != 1 against the previously pushed entry, set err_step; the entry is still pushed.
  - in_none is ignored in FILL.
- FILL, in_valid low: end of stream. Latch path_len=sp and go to DRAIN.
- DRAIN entry: the stack is read through a registered read port.
  - out_valid rises exactly 2 cycles after the first in_valid-low cycle.
  - The first beat is the last-pushed entry (the start cell), with out_first=1 and out_dir=0.
- DRAIN handshake:
  - A beat transfers on out_valid & out_ready.
  - While out_ready is low, all out_* signals hold stable.
  - On transfer, sp decrements and the next beat is presented the following cycle, with no bubble when out_ready stays high.
  - out_dir is computed from the previous transferred beat to the current cell.
  - out_last=1 when sp==1.
  - After the last transfer: out_valid=0, return to IDLE.
- Length-1 stream: the single beat has out_first=out_last=1.
- in_valid in DRAIN or NONE: entry ignored, err_drop set, no state change.
- Error flags: sticky, readable at all times, cleared only by reset or by the next stream start.
- Throughput: 1 input/cycle in FILL, 1 output/cycle in DRAIN.

Decomposition:
- Package path_pkg holds:
  - dir_t enum: LEFT/UP/RIGHT/DOWN, same codes as the solver's direction encoding;
  - state_t enum;
  - CW default;
  - function step_dir(prev, cur) returning dir_t;
  - function is_adjacent(prev, cur).
- Sub-module path_lifo:
  - DEPTH x 2*CW storage;
  - push, pop, registered read of the top entry, sp, full, empty.
- The top level holds the FSM, handshake, direction tracking and error flags.

Test Plan:
- Stream (13,13),(13,12),(12,12),(12,11),(1,1)... as 25 adjacent cells ending (1,1), out_ready=1 -> 25 beats.
  - First beat (1,1), out_first=1, out_dir=0; last beat (13,13), out_last=1; path_len=25.
  - out_dir matches each step; no error flags.
- Same stream, out_ready toggling 1,0,0,1 repeatedly -> every beat holds stable while out_ready=0; order unchanged; count 25.
- Single beat in_valid&in_none -> out_none high for exactly one cycle, out_valid never asserted, next state IDLE.
- 170 adjacent entries -> err_overflow=1; path_len=169; the 170th entry is absent from the replay.
- Stream (3,3),(3,5),(3,6) -> err_step=1; 3 beats replayed (3,6),(3,5),(3,3).
- New in_valid during DRAIN -> err_drop=1 and replay unaffected; rst_n low mid-DRAIN -> all outputs 0 immediately, IDLE.
